insn_prefetch: RTL and testbench

- Instruction prefetch buffer directly upstream of insn_decode.
- Issues sequential word fetches to instruction memory over a valid/ready request channel and accepts in-order responses.
- Buffers fetched words with their PCs in a small FIFO and presents them to decode with a valid/ready handshake.
- Handles control-flow redirects from the execute stage by flushing buffered words and dropping in-flight responses.

---
 rtl/insn_prefetch.sv | 137 +++++++++++++
 tb/tb_insn_prefetch.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/insn_prefetch.sv
// Sequential instruction prefetcher feeding decode through a small PC-tagged FIFO.
// Redirects flush the FIFO and discard every response that was already in flight.
module insn_prefetch #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
  input  logic            clock,
  input  logic            reset,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_resp_valid,
  input  logic [XLEN-1:0] mem_resp_data,
  output logic            insn_valid,
  input  logic            insn_ready,
  output logic [XLEN-1:0] insn_data,
  output logic [XLEN-1:0] insn_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);

  localparam int unsigned     AW      = $clog2(DEPTH);
  localparam int unsigned     CW      = AW + 1;
  localparam logic [XLEN-1:0] PC_STEP = {{(XLEN-3){1'b0}}, 3'b100};
  localparam logic [CW:0]     DEPTH_C = (CW+1)'(DEPTH);

  logic            run_q;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   outst_q, outst_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [XLEN-1:0] data_q [DEPTH];
  logic [XLEN-1:0] pc_q   [DEPTH];

  logic            credit_s;
  logic            req_fire_s;
  logic            pop_s;
  logic            push_s;
  logic            we_s;
  logic [XLEN-1:0] redir_pc_s;
  logic            unused_s;

  // One credit per FIFO slot: in-flight requests plus buffered words never exceed DEPTH.
  assign credit_s      = ({1'b0, outst_q} + {1'b0, count_q}) < DEPTH_C;
  assign mem_req_valid = run_q && !redirect_valid && credit_s;
  assign mem_req_addr  = fetch_pc_q;
  assign insn_valid    = (count_q != {CW{1'b0}});
  assign insn_data     = insn_valid ? data_q[rd_ptr_q] : {XLEN{1'b0}};
  assign insn_pc       = insn_valid ? pc_q[rd_ptr_q] : {XLEN{1'b0}};

  assign req_fire_s = mem_req_valid && mem_req_ready;
  assign pop_s      = insn_valid && insn_ready;
  assign push_s     = mem_resp_valid && (drop_q == {CW{1'b0}});
  assign we_s       = push_s && !redirect_valid;
  assign redir_pc_s = {redirect_pc[XLEN-1:2], 2'b00};
  assign unused_s   = ^redirect_pc[1:0];

  // Next-state for fetch pointer, response tagging, FIFO bookkeeping and drop accounting.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    outst_d    = outst_q - CW'(mem_resp_valid);
    drop_d     = drop_q;
    if (redirect_valid) begin
      // No request can fire this cycle, so everything still outstanding is stale.
      fetch_pc_d = redir_pc_s;
      resp_pc_d  = redir_pc_s;
      wr_ptr_d   = {AW{1'b0}};
      rd_ptr_d   = {AW{1'b0}};
      count_d    = {CW{1'b0}};
      drop_d     = outst_d;
    end else begin
      outst_d = outst_d + CW'(req_fire_s);
      if (req_fire_s) begin
        fetch_pc_d = fetch_pc_q + PC_STEP;
      end else begin
        fetch_pc_d = fetch_pc_q;
      end
      if (push_s) begin
        resp_pc_d = resp_pc_q + PC_STEP;
        wr_ptr_d  = wr_ptr_q + AW'(1'b1);
      end else begin
        resp_pc_d = resp_pc_q;
      end
      if (mem_resp_valid && !push_s) begin
        drop_d = drop_q - CW'(1'b1);
      end else begin
        drop_d = drop_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + AW'(1'b1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + CW'(push_s) - CW'(pop_s);
    end
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      run_q      <= 1'b0;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      wr_ptr_q   <= {AW{1'b0}};
      rd_ptr_q   <= {AW{1'b0}};
      count_q    <= {CW{1'b0}};
      outst_q    <= {CW{1'b0}};
      drop_q     <= {CW{1'b0}};
    end else begin
      run_q      <= 1'b1;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

  // FIFO storage; contents are only observed while count is nonzero.
  always_ff @(posedge clock) begin
    if (we_s) begin
      data_q[wr_ptr_q] <= mem_resp_data;
      pc_q[wr_ptr_q]   <= resp_pc_q;
    end
  end

endmodule

// File: tb/tb_insn_prefetch.sv
// Directed bench for insn_prefetch: timing, stall, redirect, random traffic, PC wrap and reset.
module tb_insn_prefetch;

  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  logic        clock;
  logic        reset;
  logic        mem_req_valid, mem_req_ready, mem_resp_valid;
  logic [31:0] mem_req_addr, mem_resp_data;
  logic        insn_valid, insn_ready;
  logic [31:0] insn_data, insn_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  logic        w_req_valid, w_resp_valid, w_insn_valid;
  logic [31:0] w_req_addr, w_resp_data, w_insn_data, w_insn_pc;

  int    total = 0;
  int    bad   = 0;
  int    pops  = 0;
  int    n_acc = 0;
  int    cyc   = 0;
  int    lat_min = 1;
  int    lat_max = 1;
  mreq_t mq[$];

  insn_prefetch #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0000_0000)) u_dut (
    .clock(clock), .reset(reset),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .insn_valid(insn_valid), .insn_ready(insn_ready), .insn_data(insn_data), .insn_pc(insn_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  insn_prefetch #(.XLEN(32), .DEPTH(4), .RESET_PC(WRAP_PC)) u_wrap (
    .clock(clock), .reset(reset),
    .mem_req_valid(w_req_valid), .mem_req_ready(1'b1), .mem_req_addr(w_req_addr),
    .mem_resp_valid(w_resp_valid), .mem_resp_data(w_resp_data),
    .insn_valid(w_insn_valid), .insn_ready(1'b1), .insn_data(w_insn_data), .insn_pc(w_insn_pc),
    .redirect_valid(1'b0), .redirect_pc(32'h0000_0000)
  );

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // In-order memory with per-request latency in [lat_min, lat_max], one response per cycle.
  initial begin : mem_model
    int    last_due;
    int    d;
    mreq_t e;
    last_due = 0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = 32'h0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        mq.delete();
        n_acc = 0;
        last_due = cyc;
      end else if (mem_req_valid && mem_req_ready) begin
        d = cyc + int'($urandom_range(lat_max, lat_min));
        if (d <= last_due) d = last_due + 1;
        last_due = d;
        e.addr = mem_req_addr;
        e.due  = d;
        mq.push_back(e);
        n_acc++;
      end
      @(posedge clock);
      cyc++;
      #1;
      if (mq.size() > 0 && mq[0].due <= cyc) begin
        mem_resp_valid = 1'b1;
        mem_resp_data  = memfn(mq[0].addr);
        void'(mq.pop_front());
      end else begin
        mem_resp_valid = 1'b0;
        mem_resp_data  = 32'h0;
      end
    end
  end

  // Fixed one-cycle memory for the wrap instance.
  initial begin : wrap_mem
    logic        hs;
    logic [31:0] a;
    w_resp_valid = 1'b0;
    w_resp_data  = 32'h0;
    forever begin
      @(negedge clock);
      hs = w_req_valid && reset;
      a  = w_req_addr;
      @(posedge clock);
      #1;
      w_resp_valid = hs;
      w_resp_data  = memfn(a);
    end
  end

  // Reference PC stream for the main instance.
  initial begin : mon_main
    logic [31:0] exp_pc;
    exp_pc = 32'h0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        exp_pc = 32'h0;
      end else if (redirect_valid) begin
        exp_pc = {redirect_pc[31:2], 2'b00};
      end else if (insn_valid && insn_ready) begin
        chk("stream_pc", insn_pc, exp_pc);
        chk("stream_data", insn_data, memfn(exp_pc));
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
    end
  end

  // Reference PC stream for the wrap instance.
  initial begin : mon_wrap
    logic [31:0] exp_w;
    exp_w = WRAP_PC;
    forever begin
      @(negedge clock);
      if (!reset) begin
        exp_w = WRAP_PC;
      end else if (w_insn_valid) begin
        chk("wrap_pc", w_insn_pc, exp_w);
        chk("wrap_data", w_insn_data, memfn(exp_w));
        exp_w = exp_w + 32'd4;
      end
    end
  end

  initial begin : stim
    int p0;
    int k;
    reset = 1'b0; mem_req_ready = 1'b1; insn_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    tick(); tick();
    @(negedge clock);
    chk("rst_req_valid", mem_req_valid, 32'd0);
    chk("rst_insn_valid", insn_valid, 32'd0);
    chk("rst_req_addr", mem_req_addr, 32'h0);
    chk("rst_insn_data", insn_data, 32'h0);
    chk("rst_insn_pc", insn_pc, 32'h0);
    chk("rst_wrap_addr", w_req_addr, WRAP_PC);

    // Reset release with a one-cycle memory and decode always ready.
    tick(); reset = 1'b1;
    @(negedge clock); chk("rel_req_valid", mem_req_valid, 32'd0);
    tick(); @(negedge clock);
    chk("t1_req_valid", mem_req_valid, 32'd1);
    chk("t1_req_addr0", mem_req_addr, 32'h0);
    chk("t1_insn_valid0", insn_valid, 32'd0);
    chk("wrap_addr0", w_req_addr, 32'hFFFF_FFF8);
    tick(); @(negedge clock);
    chk("t1_req_addr1", mem_req_addr, 32'h4);
    chk("t1_resp_valid", mem_resp_valid, 32'd1);
    chk("t1_insn_valid1", insn_valid, 32'd0);
    chk("wrap_addr1", w_req_addr, 32'hFFFF_FFFC);
    tick(); @(negedge clock);
    chk("t1_first_valid", insn_valid, 32'd1);
    chk("t1_first_pc", insn_pc, 32'h0);
    chk("t1_first_data", insn_data, memfn(32'h0));
    chk("wrap_addr2", w_req_addr, 32'h0);
    for (int i = 1; i <= 6; i++) begin
      tick(); @(negedge clock);
      chk("t1_run_valid", insn_valid, 32'd1);
      chk("t1_run_pc", insn_pc, 32'(4 * i));
    end

    // Decode stalled: exactly four requests, then backpressure.
    tick(); insn_ready = 1'b0; reset = 1'b0;
    tick(); reset = 1'b1;
    repeat (9) tick();
    @(negedge clock);
    chk("t2_accepted", n_acc, 32'd4);
    chk("t2_req_valid", mem_req_valid, 32'd0);
    chk("t2_insn_valid", insn_valid, 32'd1);
    chk("t2_head_pc", insn_pc, 32'h0);
    tick(); insn_ready = 1'b1; p0 = pops;
    tick(); @(negedge clock);
    chk("t2_resume_valid", mem_req_valid, 32'd1);
    chk("t2_resume_addr", mem_req_addr, 32'h10);
    repeat (9) tick();
    chk("t2_pops", pops - p0, 32'd10);

    // Redirect coinciding with a response and a pop, three-cycle memory.
    insn_ready = 1'b0; reset = 1'b0; lat_min = 3; lat_max = 3;
    tick(); reset = 1'b1;
    repeat (5) tick();
    redirect_valid = 1'b1; redirect_pc = 32'h100; insn_ready = 1'b1;
    @(negedge clock);
    chk("t3_pre_insn_valid", insn_valid, 32'd1);
    chk("t3_pre_resp_valid", mem_resp_valid, 32'd1);
    chk("t3_pre_req_valid", mem_req_valid, 32'd0);
    tick(); redirect_valid = 1'b0;
    @(negedge clock);
    chk("t3_flush_valid", insn_valid, 32'd0);
    chk("t3_new_req_valid", mem_req_valid, 32'd1);
    chk("t3_new_req_addr", mem_req_addr, 32'h100);
    chk("t3_stale_resp", mem_resp_valid, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick(); @(negedge clock);
      chk("t3_drop_gap", insn_valid, 32'd0);
    end
    tick(); @(negedge clock);
    chk("t3_first_valid", insn_valid, 32'd1);
    chk("t3_first_pc", insn_pc, 32'h100);
    chk("t3_first_data", insn_data, memfn(32'h100));

    // Back-to-back redirects: the last target wins, low bits ignored.
    tick(); redirect_valid = 1'b1; redirect_pc = 32'h203;
    tick(); redirect_pc = 32'h302;
    tick(); redirect_valid = 1'b0;
    k = 0;
    @(negedge clock);
    while (!insn_valid && k < 20) begin
      tick(); @(negedge clock); k++;
    end
    chk("t4_valid", insn_valid, 32'd1);
    chk("t4_pc", insn_pc, 32'h300);

    // Random ready, latency and redirects against the reference stream.
    tick(); lat_min = 1; lat_max = 3; p0 = pops;
    for (int i = 0; i < 400; i++) begin
      mem_req_ready  = ($urandom_range(3, 0) != 0);
      insn_ready     = ($urandom_range(1, 0) == 1);
      redirect_valid = ($urandom_range(15, 0) == 0);
      redirect_pc    = $urandom_range(32'h0000_0FFF, 0);
      tick();
    end
    redirect_valid = 1'b0; mem_req_ready = 1'b1; insn_ready = 1'b1;
    chk("t5_progress", 32'(pops - p0 >= 40), 32'd1);

    // Reset with requests in flight.
    insn_ready = 1'b0; lat_min = 3; lat_max = 3;
    repeat (3) tick();
    chk("t6_inflight", 32'(mq.size() > 0), 32'd1);
    reset = 1'b0;
    tick(); @(negedge clock);
    chk("t6_req_valid", mem_req_valid, 32'd0);
    chk("t6_insn_valid", insn_valid, 32'd0);
    chk("t6_req_addr", mem_req_addr, 32'h0);
    chk("t6_insn_data", insn_data, 32'h0);
    chk("t6_insn_pc", insn_pc, 32'h0);
    chk("t6_wrap_addr", w_req_addr, WRAP_PC);
    chk("t6_wrap_valid", w_insn_valid, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
